// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: walks a low column across the matrix, debounces
// whole-matrix snapshots and reports one event per newly pressed key over valid/ready.
module keypad_scan4x4 #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_pressed,
  output logic       overflow
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int DIV_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic {ST_SCAN, ST_EVAL} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [3:0]       row_meta_q, row_sync_q;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      prev_q, prev_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [15:0]      deb_q, deb_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_pressed_q, key_pressed_d;
  logic             overflow_q, overflow_d;

  logic             tick;
  logic [15:0]      new_press;

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    lowest_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_index = 4'(i);
    end
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q + 1'b1;
    col_d         = col_q;
    col_n_d       = col_n_q;
    snap_d        = snap_q;
    prev_d        = prev_q;
    stable_d      = stable_q;
    deb_d         = deb_q;
    key_code_d    = key_code_q;
    key_valid_d   = key_valid_q;
    key_pressed_d = key_pressed_q;
    overflow_d    = overflow_q;
    new_press     = '0;

    tick = (div_q == DIV_LAST);
    if (tick) div_d = '0;

    // Sample at the end of the dwell so the rows have settled for a full column period.
    if (tick) begin
      for (int r = 0; r < 4; r++) begin
        snap_d[{r[1:0], col_q}] = ~row_sync_q[r];
      end
      col_d   = col_q + 2'd1;
      col_n_d = ~(4'b0001 << col_d);
    end

    unique case (state_q)
      ST_SCAN: if (tick && col_q == 2'd3) state_d = ST_EVAL;
      ST_EVAL: state_d = ST_SCAN;
      default: state_d = ST_SCAN;
    endcase

    if (state_q == ST_EVAL) begin
      prev_d = snap_q;
      if (snap_q != prev_q)         stable_d = CNT_W'(1);
      else if (stable_q != CNT_MAX) stable_d = stable_q + 1'b1;
      if (stable_d == CNT_MAX) begin
        deb_d         = snap_q;
        key_pressed_d = |snap_q;
        new_press     = snap_q & ~deb_q;
      end
    end

    if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end

    // Only the lowest new key is reported; the rest of a simultaneous press is ignored.
    if (|new_press) begin
      if (!key_valid_q || key_ready) begin
        key_code_d  = lowest_index(new_press);
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SCAN;
      div_q         <= '0;
      col_q         <= 2'd0;
      col_n_q       <= 4'b1110;
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      snap_q        <= '0;
      prev_q        <= '0;
      stable_q      <= '0;
      deb_q         <= '0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      col_q         <= col_d;
      col_n_q       <= col_n_d;
      row_meta_q    <= row_n;
      row_sync_q    <= row_meta_q;
      snap_q        <= snap_d;
      prev_q        <= prev_d;
      stable_q      <= stable_d;
      deb_q         <= deb_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
      overflow_q    <= overflow_d;
    end
  end

  assign col_n       = col_n_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Scoreboard bench for keypad_scan4x4: a keypad model drives the rows, a scan-level
// reference model predicts events into a queue, and a monitor pops on every accept.
module tb_keypad_scan4x4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_pressed;
  logic       overflow;

  logic [15:0] keys = '0;
  int          cyc;
  int          n_vec  = 0;
  int          n_miss = 0;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;
  logic [3:0]  last_acc_code = '0;

  logic [3:0]  exp_q[$];
  logic [15:0] hist[$];
  logic [15:0] msnap = '0;
  logic [15:0] mdeb  = '0;
  logic        movf  = 1'b0;

  keypad_scan4x4 #(.CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_SCANS(4)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_pressed(key_pressed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Cycle index since reset release; the column in cycle k is (k/10)%4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one snapshot per 40-cycle scan; a state is accepted once the
  // last four scans agree, and a newly set bit yields an event with the lowest index.
  always @(negedge clk or negedge rst_n) begin
    int         col;
    logic [15:0] newp;
    logic [3:0]  code;
    if (!rst_n) begin
      exp_q.delete();
      hist.delete();
      msnap = '0;
      mdeb  = '0;
      movf  = 1'b0;
    end else begin
      if (key_valid && key_ready) movf = 1'b0;
      if (cyc % 10 == 5) begin
        col = (cyc / 10) % 4;
        for (int r = 0; r < 4; r++) msnap[r*4+col] = keys[r*4+col];
      end
      if (cyc % 40 == 35) begin
        hist.push_back(msnap);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4 && hist[0] == hist[1] && hist[1] == hist[2] && hist[2] == hist[3]) begin
          newp = msnap & ~mdeb;
          mdeb = msnap;
          if (newp != 0) begin
            code = 4'd0;
            for (int i = 15; i >= 0; i--) if (newp[i]) code = 4'(i);
            if (exp_q.size() == 0 || key_ready) exp_q.push_back(code);
            else                                movf = 1'b1;
          end
        end
      end
      if (cyc % 40 == 5) begin
        check("key_pressed", key_pressed, mdeb != 0);
        check("key_valid", key_valid, exp_q.size() != 0);
        check("overflow", overflow, movf);
        if (exp_q.size() != 0) check("held_code", key_code, exp_q[0]);
      end
    end
  end

  // Monitor: column walk every cycle, and pop/compare on every accepted event.
  always @(negedge clk) begin
    logic [3:0] exp_col;
    exp_col = 4'hF;
    exp_col[(cyc / 10) % 4] = 1'b0;
    check("col_n", col_n, exp_col);
    if (key_valid && key_ready) begin
      acc_cnt++;
      last_acc_cyc  = cyc;
      last_acc_code = key_code;
      check("event_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("key_code", key_code, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase2();
    do @(negedge clk); while (cyc % 10 != 2);
  endtask

  task automatic wait_scan_pos(input int p);
    do @(negedge clk); while (cyc % 40 != p);
  endtask

  task automatic wait_accept(input int base, input int budget, input string name);
    int n = 0;
    while (acc_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, acc_cnt > base, 1);
  endtask

  initial begin
    int a0, t0;
    logic [15:0] pat;
    rst_n     = 1'b0;
    key_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle matrix: only the column walk, no activity.
    wait_cyc(1000);
    check("t1_no_events", acc_cnt, 0);

    // Single key 9 held, then released.
    a0 = acc_cnt;
    wait_scan_pos(22);
    keys = 16'(1) << 9;
    t0 = cyc;
    wait_accept(a0, 400, "t2_event_seen");
    check("t2_latency_in_range", (last_acc_cyc - t0 >= 160) && (last_acc_cyc - t0 <= 200), 1);
    wait_phase2();
    wait_cyc(158);
    keys = '0;
    wait_cyc(320);
    check("t2_one_event", acc_cnt - a0, 1);
    check("t2_code", last_acc_code, 9);

    // Key 6 bouncing with alternating 10/20 cycle gaps for 300 cycles, then steady.
    a0 = acc_cnt;
    wait_scan_pos(2);
    for (int i = 0; i < 21; i++) begin
      keys[6] = ~keys[6];
      if (i < 20) wait_cyc((i % 2 == 0) ? 10 : 20);
    end
    check("t3_quiet_bounce", acc_cnt - a0, 0);
    wait_cyc(280);
    check("t3_one_event", acc_cnt - a0, 1);
    check("t3_code", last_acc_code, 6);
    keys = '0;
    wait_cyc(320);

    // Consumer stalled: second event is dropped and flagged.
    key_ready = 1'b0;
    wait_phase2();
    keys = 16'(1) << 5;  wait_cyc(240);
    keys = '0;           wait_cyc(240);
    keys = 16'(1) << 7;  wait_cyc(240);
    keys = '0;           wait_cyc(240);
    check("t4_valid_held", key_valid, 1);
    check("t4_code_held", key_code, 5);
    check("t4_overflow", overflow, 1);
    @(posedge clk); #1 key_ready = 1'b1;
    @(posedge clk); #1 key_ready = 1'b0;
    @(negedge clk);
    check("t4_valid_cleared", key_valid, 0);
    check("t4_overflow_cleared", overflow, 0);
    key_ready = 1'b1;

    // Simultaneous 3 and 12, then 0 added while both held.
    a0 = acc_cnt;
    wait_phase2();
    keys = (16'(1) << 3) | (16'(1) << 12);
    wait_cyc(240);
    check("t5_first_event", acc_cnt - a0, 1);
    check("t5_code_3", last_acc_code, 3);
    keys[0] = 1'b1;
    wait_cyc(240);
    check("t5_second_event", acc_cnt - a0, 2);
    check("t5_code_0", last_acc_code, 0);
    keys = '0;
    wait_cyc(320);

    // Reset while an event is pending and the key is still held.
    key_ready = 1'b0;
    wait_phase2();
    keys = 16'(1) << 10;
    begin
      int n = 0;
      while (!key_valid && n < 400) begin @(negedge clk); n++; end
      check("t6_pending_before_reset", key_valid, 1);
    end
    wait_cyc(20);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_col_n", col_n, 4'b1110);
    check("t6_rst_valid", key_valid, 0);
    check("t6_rst_code", key_code, 0);
    check("t6_rst_pressed", key_pressed, 0);
    check("t6_rst_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    key_ready = 1'b1;
    a0 = acc_cnt;
    wait_cyc(320);
    check("t6_fresh_event", acc_cnt - a0, 1);
    check("t6_code", last_acc_code, 10);
    wait_phase2();
    keys = '0;
    wait_cyc(320);

    // Random presses, occasional double keys and short glitches.
    for (int it = 0; it < 16; it++) begin
      wait_phase2();
      pat = 16'(1) << $urandom_range(15, 0);
      if ($urandom_range(3, 0) == 0) pat[$urandom_range(15, 0)] = 1'b1;
      keys = pat;
      if ($urandom_range(4, 0) == 0) begin
        wait_cyc(40 * $urandom_range(2, 1));
        keys = '0;
        wait_cyc(280);
      end else begin
        wait_cyc(40 * $urandom_range(7, 5));
        keys = '0;
        wait_cyc(40 * $urandom_range(7, 5));
      end
    end

    wait_cyc(200);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
